// File: rtl/decode_sequencer_pkg.sv
// Shared types for the instruction decode sequencer: FSM states, the
// architectural maximum instruction length and the emitted record layout.
package decode_sequencer_pkg;

   localparam int MAX_INSN_BYTES = 15;

   typedef enum logic [1:0] {
      ALIGN = 2'd0,
      RUN   = 2'd1,
      ERR   = 2'd2
   } decseq_state_t;

   // bytes: byte 0 (lowest address) occupies the most significant bits
   typedef struct packed {
      logic [63:0]                   rip;
      logic [3:0]                    len;
      logic [MAX_INSN_BYTES*8-1:0]   bytes;
      logic                          err;
   } inst_rec_t;

endpackage

// File: rtl/decode_sequencer_fifo.sv
// Byte FIFO for the decode sequencer: multi-byte push with leading-byte skip,
// variable pop of 0..15 bytes and a zero-padded 15-byte window at the head.
module decode_sequencer_fifo
   import decode_sequencer_pkg::*;
#(
   parameter int FETCH_BYTES = 8,
   parameter int DEPTH_BYTES = 32,
   localparam int AW = $clog2(DEPTH_BYTES),
   localparam int SW = $clog2(FETCH_BYTES)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          push,
   input  logic [SW-1:0]                 skip,
   input  logic [0:FETCH_BYTES*8-1]      push_data,
   input  logic [3:0]                    pop_len,
   output logic [AW:0]                   count,
   output logic [0:MAX_INSN_BYTES*8-1]   win_bytes,
   output logic [4:0]                    win_count
);

   logic [7:0]             mem     [DEPTH_BYTES];
   logic [7:0]             wr_byte [DEPTH_BYTES];
   logic [AW-1:0]          wr_off  [DEPTH_BYTES];
   logic [DEPTH_BYTES-1:0] wr_en;
   logic [AW-1:0]          head;
   logic [AW-1:0]          tail;
   logic [AW:0]            push_cnt;

   // Each storage slot decides whether it lies in [tail, tail+push_cnt) and
   // which beat byte lands in it; skipped bytes shift the beat down.
   always_comb begin
      push_cnt = push ? (AW+1)'(FETCH_BYTES) - (AW+1)'(skip) : '0;
      for (int j = 0; j < DEPTH_BYTES; j++) begin
         wr_off[j]  = AW'(j) - tail;
         wr_en[j]   = push && ({1'b0, wr_off[j]} < push_cnt);
         wr_byte[j] = 8'h00;
         if (wr_en[j])
            wr_byte[j] = push_data[(int'(wr_off[j]) + int'(skip))*8 +: 8];
      end
   end

   always_ff @(posedge clk) begin
      for (int j = 0; j < DEPTH_BYTES; j++)
         if (wr_en[j]) mem[j] <= wr_byte[j];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + AW'(pop_len);
         tail  <= tail + AW'(push_cnt);
         count <= count + push_cnt - (AW+1)'(pop_len);
      end
   end

   always_comb begin
      win_bytes = '0;
      for (int i = 0; i < MAX_INSN_BYTES; i++)
         win_bytes[i*8 +: 8] = ((AW+1)'(i) < count) ? mem[AW'(head + AW'(i))] : 8'h00;
      win_count = (count >= (AW+1)'(MAX_INSN_BYTES)) ? 5'(MAX_INSN_BYTES) : 5'(count);
   end

endmodule

// File: rtl/decode_sequencer.sv
// x86-64 decode sequencer: buffers fetch beats, presents a window at RIP to the
// external decoder and emits one registered record per decoded instruction.
// Optional statistics counters are built when DECSEQ_STATS_EN is defined.
module decode_sequencer
   import decode_sequencer_pkg::*;
#(
   parameter int          FETCH_BYTES = 8,
   parameter int          DEPTH_BYTES = 32,
   parameter logic [63:0] RESET_RIP   = 64'h0
) (
   input  logic                          clk,
   input  logic                          reset,
   // Handshakes: a transfer happens on a cycle where valid & ready are both 1;
   // a producer holding valid keeps its payload stable until that cycle.
   input  logic                          fetch_valid,
   output logic                          fetch_ready,
   input  logic [0:FETCH_BYTES*8-1]      fetch_data,
   input  logic                          redirect_valid,
   input  logic [63:0]                   redirect_rip,
   output logic [0:MAX_INSN_BYTES*8-1]   win_bytes,
   output logic [4:0]                    win_count,
   input  logic [3:0]                    dec_len,
   input  logic                          dec_err,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [63:0]                   out_rip,
   output logic [3:0]                    out_len,
   output logic [0:MAX_INSN_BYTES*8-1]   out_bytes,
   output logic                          out_err,
   output logic [1:0]                    dbg_state
`ifdef DECSEQ_STATS_EN
   ,
   output logic [31:0]                   stat_insns,
   output logic [31:0]                   stat_stalls
`endif
);

   localparam int AW = $clog2(DEPTH_BYTES);
   localparam int SW = $clog2(FETCH_BYTES);

   decseq_state_t               state, state_nxt;
   inst_rec_t                   rec;
   logic                        valid_q;
   logic [63:0]                 rip;
   logic [AW:0]                 count;
   logic                        accept, fire, err_fire, slot_free;
   logic [3:0]                  pop_len;
   logic [SW-1:0]               skip;
   logic [0:MAX_INSN_BYTES*8-1] masked;

   decode_sequencer_fifo #(
      .FETCH_BYTES (FETCH_BYTES),
      .DEPTH_BYTES (DEPTH_BYTES)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (accept),
      .skip      (skip),
      .push_data (fetch_data),
      .pop_len   (pop_len),
      .count     (count),
      .win_bytes (win_bytes),
      .win_count (win_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ALIGN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (redirect_valid) state_nxt = ALIGN;
      else begin
         case (state)
            ALIGN:   if (accept) state_nxt = RUN;
            RUN:     if (err_fire) state_nxt = ERR;
            default: state_nxt = state;
         endcase
      end
   end

   // Free space uses the start-of-cycle count; a same-cycle pop earns no credit.
   always_comb begin
      slot_free   = !valid_q || out_ready;
      fetch_ready = !reset && (state != ERR) && !redirect_valid &&
                    (count <= (AW+1)'(DEPTH_BYTES - FETCH_BYTES));
      accept      = fetch_valid && fetch_ready;
      skip        = (state == ALIGN) ? rip[SW-1:0] : '0;
      fire        = (state == RUN) && !redirect_valid && (count != '0) && !dec_err &&
                    ((AW+1)'(dec_len) <= count) && slot_free;
      err_fire    = (state == RUN) && !redirect_valid && dec_err &&
                    (count >= (AW+1)'(MAX_INSN_BYTES)) && slot_free;
      pop_len     = fire ? dec_len : 4'd0;
      for (int i = 0; i < MAX_INSN_BYTES; i++)
         masked[i*8 +: 8] = (4'(i) < dec_len) ? win_bytes[i*8 +: 8] : 8'h00;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         rec     <= '0;
         rip     <= RESET_RIP;
      end else if (redirect_valid) begin
         valid_q <= 1'b0;
         rip     <= redirect_rip;
      end else if (fire) begin
         valid_q   <= 1'b1;
         rec.rip   <= rip;
         rec.len   <= dec_len;
         rec.bytes <= masked;
         rec.err   <= 1'b0;
         rip       <= rip + 64'(dec_len);
      end else if (err_fire) begin
         valid_q   <= 1'b1;
         rec.rip   <= rip;
         rec.len   <= 4'd0;
         rec.bytes <= '0;
         rec.err   <= 1'b1;
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid = valid_q;
   assign out_rip   = rec.rip;
   assign out_len   = rec.len;
   assign out_bytes = rec.bytes;
   assign out_err   = rec.err;
   assign dbg_state = state;

`ifdef DECSEQ_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_insns  <= '0;
         stat_stalls <= '0;
      end else begin
         if (fire && stat_insns != '1)
            stat_insns <= stat_insns + 32'd1;
         if ((state == RUN) && (count != '0) && !fire && !redirect_valid && stat_stalls != '1)
            stat_stalls <= stat_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer: the bench plays the external decoder
// and checks records, window, flow control, redirect, fault and reset paths.
module tb_decode_sequencer;

   logic          clk = 1'b0;
   logic          reset;
   logic          fetch_valid;
   logic          fetch_ready;
   logic [0:63]   fetch_data;
   logic          redirect_valid;
   logic [63:0]   redirect_rip;
   logic [0:119]  win_bytes;
   logic [4:0]    win_count;
   logic [3:0]    dec_len;
   logic          dec_err;
   logic          out_valid;
   logic          out_ready;
   logic [63:0]   out_rip;
   logic [3:0]    out_len;
   logic [0:119]  out_bytes;
   logic          out_err;
   logic [1:0]    dbg_state;
`ifdef DECSEQ_STATS_EN
   logic [31:0]   stat_insns;
   logic [31:0]   stat_stalls;
`endif

   int checks   = 0;
   int failures = 0;

   decode_sequencer #(
      .FETCH_BYTES (8),
      .DEPTH_BYTES (32),
      .RESET_RIP   (64'h1000)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_valid    (fetch_valid),
      .fetch_ready    (fetch_ready),
      .fetch_data     (fetch_data),
      .redirect_valid (redirect_valid),
      .redirect_rip   (redirect_rip),
      .win_bytes      (win_bytes),
      .win_count      (win_count),
      .dec_len        (dec_len),
      .dec_err        (dec_err),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_rip        (out_rip),
      .out_len        (out_len),
      .out_bytes      (out_bytes),
      .out_err        (out_err),
      .dbg_state      (dbg_state)
`ifdef DECSEQ_STATS_EN
      ,
      .stat_insns     (stat_insns),
      .stat_stalls    (stat_stalls)
`endif
   );

   // Clock / reset
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rec_chk(input string tag, input logic [63:0] rip, input logic [3:0] len,
                          input logic [119:0] bytes);
      chk({tag, "_valid"}, 128'(out_valid), 128'(1'b1));
      chk({tag, "_rip"},   128'(out_rip),   128'(rip));
      chk({tag, "_len"},   128'(out_len),   128'(len));
      chk({tag, "_bytes"}, 128'(out_bytes), 128'(bytes));
      chk({tag, "_err"},   128'(out_err),   128'(1'b0));
   endtask

   task automatic drive_beat(input logic [63:0] d);
      fetch_valid = 1'b1;
      fetch_data  = d;
   endtask

   task automatic do_redirect(input logic [63:0] r);
      redirect_valid = 1'b1;
      redirect_rip   = r;
      cyc();
      redirect_valid = 1'b0;
   endtask

   // Beat k of a stream whose byte at offset n holds the value n
   function automatic logic [63:0] mkbeat(input int k);
      logic [63:0] d = '0;
      for (int j = 0; j < 8; j++) d = {d[55:0], 8'(8*k + j)};
      return d;
   endfunction

   initial begin
      reset          = 1'b1;
      fetch_valid    = 1'b0;
      fetch_data     = '0;
      redirect_valid = 1'b0;
      redirect_rip   = '0;
      dec_len        = 4'd1;
      dec_err        = 1'b0;
      out_ready      = 1'b1;
      cyc();

      // Reset state
      chk("rst_fetch_ready", 128'(fetch_ready), 128'(1'b0));
      chk("rst_out_valid",   128'(out_valid),   128'(1'b0));
      chk("rst_out_err",     128'(out_err),     128'(1'b0));
      chk("rst_out_rip",     128'(out_rip),     128'h0);
      chk("rst_out_len",     128'(out_len),     128'h0);
      chk("rst_out_bytes",   128'(out_bytes),   128'h0);
      chk("rst_win_count",   128'(win_count),   128'h0);
      chk("rst_state",       128'(dbg_state),   128'h0);
`ifdef DECSEQ_STATS_EN
      chk("rst_stat_insns",  128'(stat_insns),  128'h0);
      chk("rst_stat_stalls", 128'(stat_stalls), 128'h0);
`endif
      reset = 1'b0;

      // Basic decode: 48 89 E5 / 90 / C3 at 0x1000
      drive_beat(64'h4889E590C3000000);
      #1 chk("s1_fetch_ready", 128'(fetch_ready), 128'(1'b1));
      cyc();
      fetch_valid = 1'b0;
      dec_len     = 4'd3;
      chk("s1_win_count", 128'(win_count), 128'd8);
      chk("s1_win_bytes", 128'(win_bytes), 128'({64'h4889E590C3000000, 56'h0}));
      chk("s1_state_run", 128'(dbg_state), 128'h1);
      cyc();
      rec_chk("s1_r0", 64'h1000, 4'd3, {24'h4889E5, 96'h0});
      dec_len = 4'd1;
      cyc();
      rec_chk("s1_r1", 64'h1003, 4'd1, {8'h90, 112'h0});
      cyc();
      rec_chk("s1_r2", 64'h1004, 4'd1, {8'hC3, 112'h0});
      dec_len = 4'd15;
      cyc();
      chk("s1_drain", 128'(out_valid), 128'(1'b0));

      // Backpressure: hold out_ready low while beats stream in
      redirect_valid = 1'b1;
      redirect_rip   = 64'h3000;
      drive_beat(mkbeat(0));
      #1 chk("s2_redirect_blocks_fetch", 128'(fetch_ready), 128'(1'b0));
      cyc();
      redirect_valid = 1'b0;
      chk("s2_state_align", 128'(dbg_state), 128'h0);
      chk("s2_win_empty",   128'(win_count), 128'h0);
      out_ready = 1'b0;
      dec_len   = 4'd8;
      cyc();
      drive_beat(mkbeat(1));
      cyc();
      rec_chk("s2_r0", 64'h3000, 4'd8, {mkbeat(0), 56'h0});
      for (int c = 0; c < 6; c++) begin
         drive_beat(mkbeat(2 + c));
         #1 chk("s2_fetch_ready", 128'(fetch_ready), 128'(c < 3));
         cyc();
         rec_chk("s2_hold", 64'h3000, 4'd8, {mkbeat(0), 56'h0});
      end
      chk("s2_full_win_count", 128'(win_count), 128'd15);
      chk("s2_full_win_bytes", 128'(win_bytes), 128'({mkbeat(1), 56'h10111213141516}));
      fetch_valid = 1'b0;
      out_ready   = 1'b1;
      #1 chk("s2_full_no_ready", 128'(fetch_ready), 128'(1'b0));
      for (int r = 0; r < 4; r++) begin
         cyc();
         rec_chk("s2_resume", 64'h3008 + 64'(8*r), 4'd8, {mkbeat(1 + r), 56'h0});
      end
      cyc();
      chk("s2_no_dup", 128'(out_valid), 128'(1'b0));

      // 10-byte mov imm64 starting at beat offset 6
      do_redirect(64'h4006);
      out_ready = 1'b0;
      dec_len   = 4'd10;
      drive_beat(64'hAAAAAAAAAAAA48B8);
      cyc();
      chk("s3_win_count", 128'(win_count), 128'd2);
      chk("s3_win_bytes", 128'(win_bytes), 128'({16'h48B8, 104'h0}));
      drive_beat(64'h1122334455667788);
      cyc();
      chk("s3_wait_bytes", 128'(out_valid), 128'(1'b0));
      chk("s3_win_count2", 128'(win_count), 128'd10);
      fetch_valid = 1'b0;
      cyc();
      rec_chk("s3_imm64", 64'h4006, 4'd10, {16'h48B8, 64'h1122334455667788, 40'h0});

      // Redirect drops a pending record
      cyc();
      rec_chk("s4_pending", 64'h4006, 4'd10, {16'h48B8, 64'h1122334455667788, 40'h0});
      do_redirect(64'h2005);
      chk("s4_dropped", 128'(out_valid), 128'(1'b0));
      out_ready = 1'b1;
      dec_len   = 4'd1;
      drive_beat(64'h0011223344C39090);
      cyc();
      fetch_valid = 1'b0;
      chk("s4_win_count", 128'(win_count), 128'd3);
      chk("s4_win_bytes", 128'(win_bytes), 128'({24'hC39090, 96'h0}));
      cyc();
      rec_chk("s4_r0", 64'h2005, 4'd1, {8'hC3, 112'h0});

      // Decode error: stall below 15 bytes, fault record at 15
      do_redirect(64'h5004);
      dec_err = 1'b1;
      drive_beat(64'hFFFFFFFF01020304);
      cyc();
      fetch_valid = 1'b0;
      cyc();
      chk("s5_stall_valid", 128'(out_valid), 128'(1'b0));
      chk("s5_stall_count", 128'(win_count), 128'd4);
      chk("s5_stall_bytes", 128'(win_bytes), 128'({32'h01020304, 88'h0}));
      cyc();
      chk("s5_stall_hold", 128'(win_count), 128'd4);
      do_redirect(64'h5001);
      drive_beat(64'hEE01020304050607);
      cyc();
      drive_beat(64'h08090A0B0C0D0E0F);
      cyc();
      fetch_valid = 1'b0;
      chk("s5_count15",     128'(win_count), 128'd15);
      chk("s5_no_rec_yet",  128'(out_valid), 128'(1'b0));
      cyc();
      chk("s5_err_valid", 128'(out_valid), 128'(1'b1));
      chk("s5_err_flag",  128'(out_err),   128'(1'b1));
      chk("s5_err_rip",   128'(out_rip),   128'h5001);
      chk("s5_err_len",   128'(out_len),   128'h0);
      chk("s5_state_err", 128'(dbg_state), 128'h2);
      drive_beat(64'h0102030405060708);
      #1 chk("s5_err_no_fetch", 128'(fetch_ready), 128'(1'b0));
      cyc();
      chk("s5_err_no_fetch2", 128'(fetch_ready), 128'(1'b0));
      chk("s5_err_no_push",   128'(win_count),   128'd15);
      chk("s5_err_accepted",  128'(out_valid),   128'(1'b0));
      dec_err        = 1'b0;
      redirect_valid = 1'b1;
      redirect_rip   = 64'h6000;
      #1 chk("s5_redir_no_fetch", 128'(fetch_ready), 128'(1'b0));
      cyc();
      redirect_valid = 1'b0;
      out_ready      = 1'b0;
      dec_len        = 4'd2;
      drive_beat(64'h0F1E2D3C4B5A6978);
      #1 chk("s5_fetch_after_redir", 128'(fetch_ready), 128'(1'b1));
      cyc();
      fetch_valid = 1'b0;
      cyc();
      rec_chk("s6_pending", 64'h6000, 4'd2, {16'h0F1E, 104'h0});

      // Asynchronous reset mid-stream
      #2 reset = 1'b1;
      #1;
      chk("s6_rst_valid",       128'(out_valid),   128'(1'b0));
      chk("s6_rst_fetch_ready", 128'(fetch_ready), 128'(1'b0));
      chk("s6_rst_rip",         128'(out_rip),     128'h0);
      chk("s6_rst_win",         128'(win_count),   128'h0);
      chk("s6_rst_state",       128'(dbg_state),   128'h0);
`ifdef DECSEQ_STATS_EN
      chk("s6_rst_stat_insns",  128'(stat_insns),  128'h0);
      chk("s6_rst_stat_stalls", 128'(stat_stalls), 128'h0);
`endif
      cyc();
      reset     = 1'b0;
      out_ready = 1'b1;
      dec_len   = 4'd1;
      drive_beat(64'hC3C3C3C3C3C3C3C3);
      cyc();
      fetch_valid = 1'b0;
      cyc();
      rec_chk("s6_reset_rip", 64'h1000, 4'd1, {8'hC3, 112'h0});

      // Report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_sequencer.md
Name: decode_sequencer

Overview:
Sequences the x86-64 length/operand decoder. Buffers fetched instruction bytes in a byte FIFO and presents a 15-byte window at the current RIP to the external combinational decoder (prefix/opcode/operand decode). When the decoder reports a length that fits in the buffered bytes and downstream can accept, it consumes that many bytes, advances RIP and emits one instruction record. Sits between the fetch unit and the decode/issue pipeline register.

Parameters:
FETCH_BYTES, 8, bytes per fetch beat (power of 2)
DEPTH_BYTES, 32, byte FIFO capacity (power of 2, >= FETCH_BYTES+15)
RESET_RIP, 64'h0, RIP loaded on reset

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
fetch_valid  in  1  fetch beat valid
fetch_ready  out  1  beat accepted when valid&ready
fetch_data  in  FETCH_BYTES*8  packed [0:N*8-1]; byte 0 = lowest address
redirect_valid  in  1  flush and restart at redirect_rip
redirect_rip  in  64  new RIP
win_bytes  out  120  [0:119]; 15 bytes starting at RIP, bytes >= win_count are zero
win_count  out  5  buffered bytes visible in window, min(count,15)
dec_len  in  4  decoder-reported length, 1..15
dec_err  in  1  decoder cannot decode window
out_valid  out  1  instruction record valid
out_ready  in  1  downstream accepts
out_rip  out  64  RIP of emitted instruction
out_len  out  4  length in bytes
out_bytes  out  120  instruction bytes, zero beyond out_len
out_err  out  1  record is a decode fault

Behaviour:
- Reset: FIFO empty, rip=RESET_RIP, skip=RESET_RIP[2:0], state ALIGN, out_valid=0, out_err=0, out_rip/out_len/out_bytes=0, fetch_ready=0 during reset.
- count = buffered bytes; free = DEPTH_BYTES-count. fetch_ready = (state!=ERR) & !redirect_valid & (free >= FETCH_BYTES), using start-of-cycle count (no credit for same-cycle pop).
- FSM states ALIGN, RUN, ERR.
  - ALIGN: first accepted beat drops its low skip bytes, pushes FETCH_BYTES-skip bytes; -> RUN.
  - RUN: every accepted beat pushes all bytes.
  - ERR: no push, no fire; left only by redirect or reset.
- slot_free = !out_valid | out_ready.
- fire (RUN only) = count>=1 & !dec_err & dec_len<=count & slot_free. Rationale: the decoder reads bytes in order, so a length beyond count means it touched zero padding; the record waits for more bytes.
- On fire: pop dec_len bytes; output register loads out_rip=rip, out_len=dec_len, out_bytes=window masked to dec_len, out_err=0, out_valid=1; rip += dec_len (64-bit wrap). Max one instruction per cycle. Output is registered, so latency is 1 cycle from fire.
- dec_err with count<15: stall in RUN, wait for bytes. dec_err with count>=15 & slot_free: load record out_err=1, out_rip=rip, out_len=0; -> ERR.
- Output handshake: out_* stable while out_valid & !out_ready. out_valid clears on accept unless a fire occurs the same cycle.
- Same-cycle push and pop: both apply. FIFO pointers wrap modulo DEPTH_BYTES.
- Redirect (any state) wins over fire/push that cycle. Next cycle: FIFO empty, out_valid=0, rip=redirect_rip, skip=redirect_rip[2:0], state ALIGN. A pending unaccepted record is dropped.
- Async reset mid-operation returns all state to reset values immediately.

Optional Feature:
DECSEQ_STATS_EN: adds outputs stat_insns (32) and stat_stalls (32), both reset to 0 and saturating.
- stat_insns increments on each fire.
- stat_stalls increments on cycles in RUN with count>=1, no fire and no redirect.
- Without the macro these ports and counters do not exist.

Decomposition:
- DecoderTypes (shared package) receives:
  - decseq_state_t enum {ALIGN, RUN, ERR}
  - localparam MAX_INSN_BYTES=15
  - inst_rec_t struct {rip, len, bytes, err}, used for the output register.
- Sub-module byte_fifo (multi-byte push of FETCH_BYTES with skip, variable pop 0..15, window read at head) is natural. The sequencer holds the FSM, RIP and the output register.

Test Plan:
- RESET_RIP=0x1000; one beat 48 89 E5 90 C3 00 00 00; bench decoder returns len 3, 1, 1 -> records (0x1000,3), (0x1003,1), (0x1004,1) on consecutive cycles.
- out_ready=0 for 6 cycles with beats streaming -> out_* stable, count reaches 32 and fetch_ready=0 once free<8; on out_ready=1, flow resumes with no lost or duplicated record.
- 10-byte 48 B8 imm64 starting at beat offset 6; decoder returns 10 while count=2 -> no fire; after next beat, fire with out_len=10 and correct bytes.
- Redirect to 0x2005 while out_valid=1 pending -> next cycle out_valid=0; next beat drops 5 bytes; first record out_rip=0x2005.
- dec_err with count=4 -> stall, no record. dec_err with count=15 -> one record out_err=1 out_rip=current rip, fetch_ready stays 0 until redirect.
- Assert reset mid-stream with out_valid=1 -> out_valid=0 immediately, rip=RESET_RIP; with DECSEQ_STATS_EN, counters read 0.
